// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one async SRAM between two masters
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [15:0]       wdata0,
    output logic [15:0]       rdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [15:0]       wdata1,
    output logic [15:0]       rdata1,
    output logic              ack1,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    input  logic [15:0]       Data_Mem_In,
    output logic [15:0]       Data_Mem_Out,
    output logic              data_oe
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              last_grant, gnt, gnt_nx, lat_we, last_cyc, acc, done;
    logic [ADDR_W-1:0] lat_addr;
    logic [15:0]       lat_wdata;
    assign last_cyc = cnt == 4'(ACCESS_CYCLES - 1);
    // next state, grant choice and strobes; strobes come straight from state so reset drops them at once
    always_comb begin
        state_nx     = state;
        gnt_nx       = (req0 && req1) ? ~last_grant : req1;
        acc          = state == ACCESS;
        done         = state == DONE;
        CE           = ~acc;
        UB           = ~acc;
        LB           = ~acc;
        OE           = ~(acc && !lat_we);
        WE           = ~(acc && lat_we);
        data_oe      = (acc || done) && lat_we;
        ADDR         = lat_addr;
        Data_Mem_Out = lat_wdata;
        ack0         = done && !gnt;
        ack1         = done && gnt;
        if (state == IDLE && (req0 || req1)) state_nx = ACCESS;
        if (acc && last_cyc) state_nx = DONE;
        if (done) state_nx = IDLE;
    end
    // state register, request latch and access-window counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (req0 || req1)) begin
                gnt        <= gnt_nx;
                last_grant <= gnt_nx;
                lat_we     <= gnt_nx ? we1 : we0;
                lat_addr   <= gnt_nx ? addr1 : addr0;
                lat_wdata  <= gnt_nx ? wdata1 : wdata0;
                cnt        <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 4'd1;
            end
        end
    end
    // capture read data for the granted port on the last strobe cycle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == ACCESS && last_cyc && !lat_we) begin
            if (gnt) rdata1 <= Data_Mem_In;
            else     rdata0 <= Data_Mem_In;
        end
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 1Mx16 SRAM between two requesters.
- Port 0 is the SLC-3 CPU memory path; port 1 is a secondary master such as a video line fetcher or debug loader.
- Sequences the active-low SRAM control strobes, drives ADDR, and gives the write-data drive enable to the existing 16-bit tristate buffer.
- Round-robin arbitration with a fixed-length access window and a one-cycle ack per transfer.

Parameters:
ACCESS_CYCLES, 2, number of cycles the SRAM strobes are held active per access (legal range 1..15)
ADDR_W, 20, SRAM address width

Ports:
Clk  in  1  system clock, all state changes on rising edge
Reset  in  1  asynchronous, active-low reset
req0  in  1  port 0 request; hold high with addr0/we0/wdata0 stable until ack0
we0  in  1  port 0: 1 = write, 0 = read
addr0  in  ADDR_W  port 0 word address
wdata0  in  16  port 0 write data
rdata0  out  16  port 0 read data, valid from ack0 until next port 0 read completes
ack0  out  1  port 0 transfer complete, one-cycle pulse
req1, we1, addr1, wdata1, rdata1, ack1  (same widths and meaning as port 0, for port 1)
CE  out  1  SRAM chip enable, active-low
UB  out  1  upper byte enable, active-low
LB  out  1  lower byte enable, active-low
OE  out  1  SRAM output enable, active-low
WE  out  1  SRAM write enable, active-low
ADDR  out  ADDR_W  SRAM address
Data_Mem_In  in  16  data read from the SRAM bus via the tristate
Data_Mem_Out  out  16  data to drive onto the SRAM bus
data_oe  out  1  1 = tristate drives Data_Mem_Out onto the bus

Behaviour:
- Reset (Reset=0, asynchronous) forces:
  - CE=UB=LB=OE=WE=1; data_oe=0; ADDR=0; Data_Mem_Out=0.
  - ack0=ack1=0; rdata0=rdata1=0.
  - state=IDLE; cnt=0; last_grant=1, so port 0 wins the first tie.
- Reset mid-access aborts it immediately: strobes deassert asynchronously and no ack is issued.
- States are IDLE, ACCESS, DONE.
- IDLE:
  - All strobes inactive; data_oe=0.
  - On an edge with any req high, pick the granted port:
    - only one req high: that port;
    - both high: the port != last_grant.
  - Latch the granted port's addr/we/wdata into internal registers, set last_grant, cnt=0, go to ACCESS.
  - Requests are sampled only in IDLE.
- ACCESS:
  - CE=0, UB=0, LB=0; ADDR = latched address.
  - Read: OE=0, WE=1, data_oe=0.
  - Write: OE=1, WE=0, data_oe=1, Data_Mem_Out = latched wdata.
  - cnt increments each cycle.
  - When cnt==ACCESS_CYCLES-1, on that edge:
    - read: capture Data_Mem_In into the granted port's rdata;
    - go to DONE.
- DONE:
  - CE=UB=LB=OE=WE=1; ADDR holds.
  - For a write, data_oe stays 1 and Data_Mem_Out holds (data hold after WE rises).
  - ack of the granted port = 1 for exactly this cycle.
  - Next edge: go to IDLE.
- Latency and throughput:
  - req sampled at edge k; strobes active cycles k+1 .. k+ACCESS_CYCLES; ack at cycle k+ACCESS_CYCLES+1.
  - Minimum spacing between accesses is ACCESS_CYCLES+2 cycles.
- Handshake:
  - A requester may deassert req or change its inputs in the cycle after ack.
  - A req still high when IDLE samples it is a new request.
  - Changing addr/we/wdata while waiting has no effect on an access already latched.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1. Neither port waits more than one access.
- Non-granted port: its ack stays 0 and its rdata is unchanged.
- Only one of ack0/ack1 may be high in any cycle.
- Strobe exclusivity: OE=0 and WE=0 never occur in the same cycle. data_oe=1 never coincides with OE=0.
- No byte-lane writes: UB and LB always move together.
- ADDR passes through full width; callers with 16-bit addresses zero-extend.

Test Plan:
1. Port 0 single read: preload SRAM model [0x00123]=0xBEEF; req0=1, we0=0, addr0=0x00123 -> OE low for exactly 2 cycles, ADDR=0x00123, ack0 one cycle at sample+3, rdata0=0xBEEF, ack1 stays 0.
2. Port 1 single write: addr1=0x0F00F, wdata1=0x1234, we1=1 -> WE low 2 cycles, OE stays 1, data_oe=1 through ACCESS and DONE, model [0x0F00F]=0x1234, ack1 pulses once.
3. Simultaneous contention: req0 and req1 both held high for 4 transfers, reads at 0x10 and 0x20 -> grant order 0,1,0,1 (first after reset is port 0), acks 4 cycles apart, each rdata matches its own address.
4. Back-to-back same port: req0 held high across ack with the address changed to 0x11 the cycle after ack -> second access uses 0x11; no ack lost or duplicated.
5. Reset mid-access: assert Reset=0 during the 2nd ACCESS cycle of a write -> CE/WE/OE=1 and data_oe=0 immediately (before the next edge), no ack; after release, state IDLE and a new req0 completes normally.
6. ACCESS_CYCLES=1 instance: a read completes with ack at sample+2; rdata captured correctly; OE low exactly 1 cycle.
